// File: rtl/fma_round_pack.sv
// Final FMA stage: IEEE-754 single-precision rounding, range handling and packing.
// Two registered stages (increment, then carry/range/pack) behind a valid/ready handshake.
module fma_round_pack #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      EXP_WIDTH = 8,
  parameter int unsigned      SIG_WIDTH = 23,
  parameter int unsigned      BIAS      = 127,
  parameter logic [WIDTH-1:0] CODE_NAN  = 32'h7FC0_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIG_WIDTH+3:0] normalized,
  input  logic [EXP_WIDTH-1:0] norm_exp,
  input  logic                 sign,
  input  logic                 is_nan,
  input  logic                 is_inf,
  input  logic                 is_zero,
  input  logic                 invalid_in,
  input  logic [2:0]           rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [3:0]           flags
);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [EXP_WIDTH:0]   EXP_OVF   = (EXP_WIDTH+1)'(2*BIAS+1);
  localparam logic [EXP_WIDTH-1:0] EXP_ONES  = {EXP_WIDTH{1'b1}};
  localparam logic [EXP_WIDTH-1:0] EXP_ZERO  = {EXP_WIDTH{1'b0}};
  localparam logic [EXP_WIDTH-1:0] EXP_MAXF  = {{(EXP_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [SIG_WIDTH-1:0] FRAC_ZERO = {SIG_WIDTH{1'b0}};
  localparam logic [SIG_WIDTH-1:0] FRAC_ONES = {SIG_WIDTH{1'b1}};

  function automatic logic round_inc(input logic [2:0] mode, input logic sgn,
                                     input logic lsb, input logic g,
                                     input logic r, input logic s);
    logic inexact;
    logic inc;
    inexact = g | r | s;
    case (mode)
      RM_RNE:  inc = g & (r | s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sgn & inexact;
      RM_RUP:  inc = ~sgn & inexact;
      RM_RMM:  inc = g;
      default: inc = g & (r | s | lsb);
    endcase
    return inc;
  endfunction

  // Directed modes saturate to the largest finite value instead of infinity.
  function automatic logic [WIDTH-1:0] overflow_pack(input logic [2:0] mode, input logic sgn);
    logic [WIDTH-1:0] inf_w;
    logic [WIDTH-1:0] max_w;
    logic [WIDTH-1:0] res;
    inf_w = {sgn, EXP_ONES, FRAC_ZERO};
    max_w = {sgn, EXP_MAXF, FRAC_ONES};
    case (mode)
      RM_RTZ:  res = max_w;
      RM_RDN:  res = sgn ? inf_w : max_w;
      RM_RUP:  res = sgn ? max_w : inf_w;
      default: res = inf_w;
    endcase
    return res;
  endfunction

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_sign_q, s1_inexact_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_nv_q;
  logic [2:0]             s1_mode_q;
  logic [EXP_WIDTH-1:0]   s1_exp_q;
  logic [SIG_WIDTH+1:0]   s1_sig_q;
  logic                   s1_inc_s;
  logic                   s1_inexact_s;
  logic [SIG_WIDTH+1:0]   s1_sig_s;

  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [3:0]             flags_q, flags_d;

  logic                   s2_adv_s;
  logic                   s1_load_s;
  logic                   s2_load_s;
  logic [EXP_WIDTH:0]     exp_sum_s;
  logic [SIG_WIDTH-1:0]   frac_s;
  logic [WIDTH-1:0]       pack_res_s;
  logic [3:0]             pack_flags_s;
  logic                   unused_hidden_s;

  assign s2_adv_s        = ~out_valid_q | out_ready;
  assign in_ready        = ~s1_valid_q | s2_adv_s;
  assign s1_load_s       = in_valid & in_ready;
  assign s2_load_s       = s1_valid_q & s2_adv_s;
  assign unused_hidden_s = s1_sig_q[SIG_WIDTH];

  // S1 rounding increment applied to the 24-bit significand.
  always_comb begin
    s1_inc_s     = round_inc(rnd_mode, sign, normalized[3], normalized[2],
                             normalized[1], normalized[0]);
    s1_inexact_s = |normalized[2:0];
    s1_sig_s     = {1'b0, normalized[SIG_WIDTH+3:3]} + {{(SIG_WIDTH+1){1'b0}}, s1_inc_s};
    if (in_ready) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S1 pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_inexact_q <= 1'b0;
      s1_nan_q     <= 1'b0;
      s1_inf_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_nv_q      <= 1'b0;
      s1_mode_q    <= 3'b000;
      s1_exp_q     <= EXP_ZERO;
      s1_sig_q     <= {(SIG_WIDTH+2){1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load_s) begin
        s1_sign_q    <= sign;
        s1_inexact_q <= s1_inexact_s;
        s1_nan_q     <= is_nan;
        s1_inf_q     <= is_inf;
        s1_zero_q    <= is_zero;
        s1_nv_q      <= invalid_in;
        s1_mode_q    <= rnd_mode;
        s1_exp_q     <= norm_exp;
        s1_sig_q     <= s1_sig_s;
      end
    end
  end

  // S2 carry-out renormalisation, range checks and special-operand priority.
  always_comb begin
    exp_sum_s = {1'b0, s1_exp_q} + {{EXP_WIDTH{1'b0}}, s1_sig_q[SIG_WIDTH+1]};
    if (s1_sig_q[SIG_WIDTH+1]) begin
      frac_s = FRAC_ZERO;
    end else begin
      frac_s = s1_sig_q[SIG_WIDTH-1:0];
    end

    if (s1_nan_q) begin
      pack_res_s   = CODE_NAN;
      pack_flags_s = {s1_nv_q, 3'b000};
    end else if (s1_inf_q) begin
      pack_res_s   = {s1_sign_q, EXP_ONES, FRAC_ZERO};
      pack_flags_s = {s1_nv_q, 3'b000};
    end else if (s1_zero_q) begin
      pack_res_s   = {s1_sign_q, EXP_ZERO, FRAC_ZERO};
      pack_flags_s = {s1_nv_q, 3'b000};
    end else if (s1_exp_q == EXP_ZERO) begin
      pack_res_s   = {s1_sign_q, EXP_ZERO, FRAC_ZERO};
      pack_flags_s = {s1_nv_q, 3'b011};
    end else if (exp_sum_s >= EXP_OVF) begin
      pack_res_s   = overflow_pack(s1_mode_q, s1_sign_q);
      pack_flags_s = {s1_nv_q, 3'b101};
    end else begin
      pack_res_s   = {s1_sign_q, exp_sum_s[EXP_WIDTH-1:0], frac_s};
      pack_flags_s = {s1_nv_q, 2'b00, s1_inexact_q};
    end

    if (s2_adv_s) begin
      out_valid_d = s1_valid_q;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (s2_load_s) begin
      result_d = pack_res_s;
      flags_d  = pack_flags_s;
    end else begin
      result_d = result_q;
      flags_d  = flags_q;
    end
  end

  // S2 output registers; hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule
